// File: rtl/heartbeat_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : heartbeat_gen
// Description : Multi-channel status-LED pattern generator. Each channel has
//               its own mode and tick divider and can be rewritten at run time.
//               Optional brightness PWM: define HEARTBEAT_GEN_PWM_EN.
// Revision    : 1.0  initial release
// ============================================================================
module heartbeat_gen #(
   parameter int unsigned      CHANNELS = 4,
   parameter int unsigned      DIV_W    = 27,
   parameter logic [DIV_W-1:0] DEF_DIV  = 27'd99999999,
   parameter logic [1:0]       DEF_MODE = 2'b10
) (
   input  logic                clk_i,
   input  logic                nreset_i,
   input  logic                cfg_we_i,
   input  logic [3:0]          cfg_ch_i,
   input  logic [1:0]          cfg_mode_i,
   input  logic [DIV_W-1:0]    cfg_div_i,
   input  logic                sync_i,
   input  logic [7:0]          duty_i,
   output logic [CHANNELS-1:0] hb_o,
   output logic [CHANNELS-1:0] tick_o
);

   localparam logic [1:0] c_mode_off   = 2'b00;
   localparam logic [1:0] c_mode_on    = 2'b01;
   localparam logic [1:0] c_mode_blink = 2'b10;
   localparam logic [1:0] c_mode_dbl   = 2'b11;

   logic w_pwm_on;

`ifdef HEARTBEAT_GEN_PWM_EN
   logic [7:0] r_pwm_cnt;

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_pwm_cnt <= 8'd0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
   end

   // duty_i=255 leaves one dark slot per 256 clocks
   assign w_pwm_on = (r_pwm_cnt < duty_i);
`else
   logic w_unused_duty;

   assign w_unused_duty = ^duty_i;
   assign w_pwm_on      = 1'b1;
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DIV_W-1:0] r_cntr;
      logic [DIV_W-1:0] r_div;
      logic [1:0]       r_mode;
      logic [2:0]       r_phase;
      logic             r_blink;
      logic             r_hb;
      logic             r_tick;

      logic [DIV_W-1:0] w_cntr_nx;
      logic [DIV_W-1:0] w_div_nx;
      logic [1:0]       w_mode_nx;
      logic [2:0]       w_phase_nx;
      logic             w_blink_nx;
      logic             w_raw_nx;
      logic             w_tick;
      logic             w_wr;

      assign w_tick = (r_cntr == r_div);
      // Out-of-range channel indices never match any generated channel
      assign w_wr   = cfg_we_i && (cfg_ch_i == 4'(c));

      always_comb begin
         w_cntr_nx  = r_cntr + DIV_W'(1);
         w_div_nx   = r_div;
         w_mode_nx  = r_mode;
         w_phase_nx = r_phase;
         w_blink_nx = r_blink;
         if (w_wr) begin
            w_div_nx   = cfg_div_i;
            w_mode_nx  = cfg_mode_i;
            w_cntr_nx  = '0;
            w_phase_nx = 3'd0;
            w_blink_nx = 1'b0;
         end else if (sync_i) begin
            w_cntr_nx  = '0;
            w_phase_nx = 3'd0;
            w_blink_nx = 1'b0;
         end else if (w_tick) begin
            w_cntr_nx  = '0;
            w_phase_nx = r_phase + 3'd1;
            w_blink_nx = ~r_blink;
         end
      end

      // Pattern is derived from next-state so hb_o lands with the new timing
      always_comb begin
         w_raw_nx = 1'b0;
         case (w_mode_nx)
            c_mode_off:   w_raw_nx = 1'b0;
            c_mode_on:    w_raw_nx = 1'b1;
            c_mode_blink: w_raw_nx = w_blink_nx;
            c_mode_dbl:   w_raw_nx = (w_phase_nx == 3'd0) || (w_phase_nx == 3'd2);
            default:      w_raw_nx = 1'b0;
         endcase
      end

      always_ff @(posedge clk_i or negedge nreset_i) begin
         if (!nreset_i) begin
            r_cntr  <= '0;
            r_div   <= DEF_DIV;
            r_mode  <= DEF_MODE;
            r_phase <= 3'd0;
            r_blink <= 1'b0;
            r_hb    <= 1'b0;
            r_tick  <= 1'b0;
         end else begin
            r_cntr  <= w_cntr_nx;
            r_div   <= w_div_nx;
            r_mode  <= w_mode_nx;
            r_phase <= w_phase_nx;
            r_blink <= w_blink_nx;
            r_hb    <= w_raw_nx & w_pwm_on;
            r_tick  <= w_tick;
         end
      end

      assign hb_o[c]   = r_hb;
      assign tick_o[c] = r_tick;
   end

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_heartbeat_gen
// Description : Self-checking bench for heartbeat_gen (vector table,
//               scoreboard-fed reference model, hand-written corner sequences).
// Revision    : 1.0  initial release
// ============================================================================
module tb_heartbeat_gen;

   localparam int             CH   = 4;
   localparam int             DW   = 8;
   localparam logic [DW-1:0]  DDIV = 8'd3;

   logic          clk_i = 1'b0;
   logic          nreset_i;
   logic          cfg_we_i;
   logic [3:0]    cfg_ch_i;
   logic [1:0]    cfg_mode_i;
   logic [DW-1:0] cfg_div_i;
   logic          sync_i;
   logic [7:0]    duty_i;
   logic [CH-1:0] hb_o;
   logic [CH-1:0] tick_o;

   heartbeat_gen #(
      .CHANNELS (CH),
      .DIV_W    (DW),
      .DEF_DIV  (DDIV),
      .DEF_MODE (2'b10)
   ) dut (
      .clk_i      (clk_i),
      .nreset_i   (nreset_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_mode_i (cfg_mode_i),
      .cfg_div_i  (cfg_div_i),
      .sync_i     (sync_i),
      .duty_i     (duty_i),
      .hb_o       (hb_o),
      .tick_o     (tick_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [CH-1:0] hb;
      logic [CH-1:0] tick;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      logic          we;
      logic [3:0]    ch;
      logic [1:0]    mode;
      logic [DW-1:0] div;
      logic          sync;
      logic [CH-1:0] exp_hb;
      logic [CH-1:0] exp_tick;
   } vec_t;

   vec_t vt[12];

   // reference model state
   logic [DW-1:0] m_cnt [CH];
   logic [DW-1:0] m_div [CH];
   logic [1:0]    m_mode[CH];
   logic [2:0]    m_ph  [CH];
   logic          m_bl  [CH];
   logic [7:0]    m_pwm;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_cnt[i]  = '0;
         m_div[i]  = DDIV;
         m_mode[i] = 2'b10;
         m_ph[i]   = 3'd0;
         m_bl[i]   = 1'b0;
      end
      m_pwm = 8'd0;
   endtask

   task automatic model_step(input logic we, input logic [3:0] ch, input logic [1:0] md,
                             input logic [DW-1:0] dv, input logic sy);
      exp_t e;
      logic on;
      logic tk;
      logic raw;
`ifdef HEARTBEAT_GEN_PWM_EN
      on    = (m_pwm < duty_i);
      m_pwm = m_pwm + 8'd1;
`else
      on = 1'b1;
`endif
      for (int i = 0; i < CH; i++) begin
         tk        = (m_cnt[i] == m_div[i]);
         e.tick[i] = tk;
         if (we && (int'(ch) == i)) begin
            m_mode[i] = md;
            m_div[i]  = dv;
            m_cnt[i]  = '0;
            m_ph[i]   = 3'd0;
            m_bl[i]   = 1'b0;
         end else if (sy) begin
            m_cnt[i] = '0;
            m_ph[i]  = 3'd0;
            m_bl[i]  = 1'b0;
         end else if (tk) begin
            m_cnt[i] = '0;
            m_ph[i]  = m_ph[i] + 3'd1;
            m_bl[i]  = !m_bl[i];
         end else begin
            m_cnt[i] = m_cnt[i] + 8'd1;
         end
         case (m_mode[i])
            2'b00:   raw = 1'b0;
            2'b01:   raw = 1'b1;
            2'b10:   raw = m_bl[i];
            default: raw = !m_ph[i][0] && !m_ph[i][2];
         endcase
         e.hb[i] = raw & on;
      end
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic we, input logic [3:0] ch, input logic [1:0] md,
                        input logic [DW-1:0] dv, input logic sy);
      exp_t e;
      cfg_we_i   = we;
      cfg_ch_i   = ch;
      cfg_mode_i = md;
      cfg_div_i  = dv;
      sync_i     = sy;
      model_step(we, ch, md, dv, sy);
      @(posedge clk_i);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check("sb_hb", 32'(hb_o), 32'(e.hb));
         check("sb_tick", 32'(tick_o), 32'(e.tick));
      end
      cfg_we_i = 1'b0;
      sync_i   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 2'b00, '0, 1'b0);
   endtask

   task automatic do_reset();
      nreset_i = 1'b0;
      cfg_we_i = 1'b0;
      sync_i   = 1'b0;
      #1;
      check("rst_hb_async", 32'(hb_o), 32'd0);
      check("rst_tick_async", 32'(tick_o), 32'd0);
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_hb_hold", 32'(hb_o), 32'd0);
      check("rst_tick_hold", 32'(tick_o), 32'd0);
      model_reset();
      sb_q.delete();
      @(negedge clk_i);
      nreset_i = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:15] pat;
      logic [CH-1:0] tk_hist[8];
      int ones;

      cfg_we_i   = 1'b0;
      cfg_ch_i   = 4'd0;
      cfg_mode_i = 2'b00;
      cfg_div_i  = '0;
      sync_i     = 1'b0;
      duty_i     = 8'hFF;
      nreset_i   = 1'b1;
      @(negedge clk_i);

      // default blink, div 3: toggle every 4 clocks; then ch2 on/off writes
      vt[0]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'h0, 4'h0};
      vt[1]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'h0, 4'h0};
      vt[2]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'h0, 4'h0};
      vt[3]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'hF, 4'hF};
      vt[4]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'hF, 4'h0};
      vt[5]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'hF, 4'h0};
      vt[6]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'hF, 4'h0};
      vt[7]  = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'h0, 4'hF};
      vt[8]  = '{1'b1, 4'd2, 2'b01, 8'd3, 1'b0, 4'h4, 4'h0};
      vt[9]  = '{1'b1, 4'd2, 2'b00, 8'd3, 1'b0, 4'h0, 4'h0};
      vt[10] = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'h0, 4'h0};
      vt[11] = '{1'b0, 4'd0, 2'b00, 8'd0, 1'b0, 4'hB, 4'hB};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(vt[i].we, vt[i].ch, vt[i].mode, vt[i].div, vt[i].sync);
         check("tbl_hb", 32'(hb_o), 32'(vt[i].exp_hb));
         check("tbl_tick", 32'(tick_o), 32'(vt[i].exp_tick));
      end

      // out-of-range channel write must be invisible
      cycle(1'b1, 4'd15, 2'b01, 8'd0, 1'b0);
      idle(2);

      // double-pulse: high 2, low 2, high 2, low 10
      pat = 16'b1100_1100_0000_0000;
      cycle(1'b1, 4'd1, 2'b11, 8'd1, 1'b0);
      check("dbl_pat", 32'(hb_o[1]), 32'(pat[0]));
      for (int k = 1; k < 32; k++) begin
         idle(1);
         check("dbl_pat", 32'(hb_o[1]), 32'(pat[k % 16]));
      end

      // drifting channels, then common restart
      cycle(1'b1, 4'd0, 2'b10, 8'd2, 1'b0);
      idle(2);
      cycle(1'b1, 4'd3, 2'b10, 8'd4, 1'b0);
      idle(5);
      cycle(1'b0, 4'd0, 2'b00, 8'd0, 1'b1);
      check("sync_hb", 32'(hb_o), 32'h2);
      for (int k = 1; k < 7; k++) begin
         idle(1);
         tk_hist[k] = tick_o;
      end
      for (int k = 1; k < 6; k++) begin
         check("sync_tick0", 32'(tk_hist[k][0]), (k == 3) ? 32'd1 : 32'd0);
         check("sync_tick3", 32'(tk_hist[k][3]), (k == 5) ? 32'd1 : 32'd0);
      end

      // random traffic including invalid channels, div 0 and write+sync collisions
      for (int k = 0; k < 120; k++) begin
         duty_i = 8'($urandom_range(0, 255));
         cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 5)),
               2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)),
               ($urandom_range(0, 15) == 0));
      end
      duty_i = 8'hFF;

      // reset mid-pattern
      @(posedge clk_i);
      #3;
      do_reset();
      idle(6);

`ifdef HEARTBEAT_GEN_PWM_EN
      duty_i = 8'd64;
      cycle(1'b1, 4'd0, 2'b01, 8'd3, 1'b0);
      ones = 0;
      for (int k = 0; k < 256; k++) begin
         idle(1);
         ones += int'(hb_o[0]);
      end
      check("pwm_duty64", 32'(ones), 32'd64);
      duty_i = 8'd0;
      ones   = 0;
      for (int k = 0; k < 256; k++) begin
         idle(1);
         ones += int'(hb_o[0]);
      end
      check("pwm_duty0", 32'(ones), 32'd0);
`else
      ones = 0;
      duty_i = 8'd0;
      cycle(1'b1, 4'd0, 2'b01, 8'd3, 1'b0);
      for (int k = 0; k < 20; k++) begin
         idle(1);
         ones += int'(hb_o[0]);
      end
      check("duty_ignored", 32'(ones), 32'd20);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
